// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word-aligned instruction-memory requests and buffers
// in-order responses for the CPU. Define FETCH_PERF_EN to add fetch/bubble performance counters.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           bubble_count
`endif
);

    localparam int unsigned           PW       = $clog2(DEPTH);
    localparam int unsigned           CW       = $clog2(DEPTH) + 1;
    localparam logic [CW:0]           DepthLim = DEPTH[CW:0];
    localparam logic [ADDR_WIDTH-1:0] Step     = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic                  req_valid_q, req_valid_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [31:0]           q_instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_q    [DEPTH];

    logic                  req_fire;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redirect_tgt;
    logic [CW:0]           credit_used;

    always_comb begin
        req_fire     = req_valid_q & imem_req_ready;
        pop          = instr_valid_q & instr_ready;
        // A response coinciding with a redirect belongs to the old stream and is discarded.
        push         = imem_rsp_valid & (state_q == StFetch) & ~redirect_valid;
        redirect_tgt = redirect_pc & ~ADDR_WIDTH'(3);

        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        count_d       = count_q + CW'(push) - CW'(pop);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + Step;
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + Step;
            wptr_d   = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end

        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: state_d = StFetch;
            StFlush: begin
                if (imem_rsp_valid) begin
                    drop_d = drop_q - 1'b1;
                end
                if (drop_d == '0) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            // A second redirect while flushing must not forget responses still owed.
            if (state_q != StFlush) begin
                drop_d = outstanding_d;
            end
            state_d = StFlush;
        end

        credit_used   = {1'b0, outstanding_d} + {1'b0, count_d};
        req_valid_d   = (state_d == StFetch) && (credit_used < DepthLim);
        instr_valid_d = (count_d != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            q_instr_q     <= '{default: '0};
            q_pc_q        <= '{default: '0};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            if (push) begin
                q_instr_q[wptr_q] <= imem_rsp_data;
                q_pc_q[wptr_q]    <= rsp_pc_q;
            end
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign instr_valid    = instr_valid_q;
    assign instruction    = q_instr_q[rptr_q];
    assign instr_pc       = q_pc_q[rptr_q];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] bubble_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            if (pop) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (instr_ready && !instr_valid_q) begin
                bubble_count_q <= bubble_count_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

    // The request credit rule guarantees a free slot for every response.
    no_overflow_a: assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && (count_q == DepthLim[CW-1:0])));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized memory/CPU timing against a
// transaction-level model of the expected instruction stream.
module tb_instr_fetch_unit;

    localparam int unsigned AW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [31:0]   imem_rsp_data  = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [31:0]   instruction;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc    = '0;
`ifdef FETCH_PERF_EN
    logic [31:0]   fetch_count;
    logic [31:0]   bubble_count;
`endif

    instr_fetch_unit #(
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RESET_PC  (RST_PC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count),
        .bubble_count  (bubble_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        pend[$];    // accepted requests awaiting their memory response
    ent_t        exp_q[$];   // instructions the CPU should see next, in order
    logic [31:0] popped[$];  // PCs actually consumed by the CPU
    logic [31:0] next_addr;
    int unsigned epoch;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_fires, n_pops, n_bubbles;
    int unsigned mem_rdy_pct = 100;
    int unsigned cpu_rdy_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic        smp_fire, smp_rsp, smp_valid, smp_req_valid;
    logic [31:0] smp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic drive_inputs();
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        instr_ready    = ($urandom_range(99) < cpu_rdy_pct);
    endtask

    // One clock cycle: observe at the falling edge, update the model, drive the next inputs.
    task automatic tick();
        ent_t e;
        req_t r;
        @(negedge clock);
        smp_req_valid = imem_req_valid;
        smp_addr      = imem_req_addr;
        smp_fire      = imem_req_valid && imem_req_ready;
        smp_rsp       = imem_rsp_valid;
        smp_valid     = instr_valid;
        n_checks++;
        if (instr_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL instr_valid cyc=%0d: got %b want %b", cyc, instr_valid,
                     exp_q.size() != 0);
        end
        if (imem_req_valid === 1'b1) begin
            n_checks++;
            if (imem_req_addr !== next_addr) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, imem_req_addr, next_addr);
            end
            n_checks++;
            if (pend.size() + exp_q.size() >= int'(DEPTH)) begin
                n_fail++;
                $display("FAIL req_credit cyc=%0d: got in_flight+queued=%0d want <%0d", cyc,
                         pend.size() + exp_q.size(), DEPTH);
            end
        end
        if (instr_valid === 1'b1 && instr_ready) begin
            n_pops++;
            popped.push_back(instr_pc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL deliver cyc=%0d: got pc=%h want no instruction", cyc, instr_pc);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e.pc || instruction !== e.data) begin
                    n_fail++;
                    $display("FAIL deliver cyc=%0d: got pc=%h data=%h want pc=%h data=%h", cyc,
                             instr_pc, instruction, e.pc, e.data);
                end
            end
        end
        if (instr_ready && instr_valid === 1'b0) n_bubbles++;
        if (imem_rsp_valid) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !redirect_valid) exp_q.push_back('{r.addr, mem_word(r.addr)});
        end
        if (smp_fire) begin
            pend.push_back('{imem_req_addr, epoch, cyc + $urandom_range(lat_max, lat_min)});
            next_addr = next_addr + 32'd4;
            n_fires++;
        end
        if (redirect_valid) begin
            epoch++;
            exp_q.delete();
            next_addr = redirect_pc & ~32'h3;
        end
        @(posedge clock);
        cyc++;
        #1;
        redirect_valid = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        pend.delete();
        exp_q.delete();
        popped.delete();
        next_addr      = RST_PC;
        epoch          = 0;
        n_fires        = 0;
        n_pops         = 0;
        n_bubbles      = 0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        drive_inputs();
    endtask

    task automatic test_reset();
        int          first;
        logic [31:0] want;
        mem_rdy_pct = 100; cpu_rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (6) tick();
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
        end
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid);
        end
        n_checks++;
        if (instruction !== 32'h0) begin
            n_fail++; $display("FAIL rst_instruction: got %h want 0", instruction);
        end
        n_checks++;
        if (instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc);
        end
        n_checks++;
        if (imem_req_addr !== RST_PC) begin
            n_fail++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RST_PC);
        end
        do_reset();
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            tick();
            if (smp_valid === 1'b1) first = i;
        end
        n_checks++;
        if (first != 3) begin
            n_fail++; $display("FAIL first_valid_cycle: got %0d want 3", first);
        end
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            want = 32'(k * 4);
            n_checks++;
            if (popped.size() <= k || popped[k] !== want) begin
                n_fail++;
                $display("FAIL startup_pc[%0d]: got %h want %h", k,
                         (popped.size() > k) ? popped[k] : 32'hx, want);
            end
        end
    endtask

    task automatic test_backpressure();
        mem_rdy_pct = 100; cpu_rdy_pct = 0; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (20) tick();
        n_checks++;
        if (n_fires != int'(DEPTH)) begin
            n_fail++; $display("FAIL bp_requests: got %0d want %0d", n_fires, DEPTH);
        end
        n_checks++;
        if (smp_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_req_valid: got %b want 0", smp_req_valid);
        end
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head: got valid=%b pc=%h want 1/0", instr_valid, instr_pc);
        end
        cpu_rdy_pct = 100;
        instr_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (n_pops != 4) begin
            n_fail++; $display("FAIL bp_drain: got %0d pops want 4", n_pops);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (popped.size() <= k || popped[k] !== 32'(k * 4)) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", k,
                                   (popped.size() > k) ? popped[k] : 32'hx, 32'(k * 4));
            end
        end
    endtask

    task automatic test_req_stall();
        mem_rdy_pct = 0; cpu_rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (smp_req_valid !== 1'b1 || smp_addr !== 32'h0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b addr=%h want 1/0", i,
                                   smp_req_valid, smp_addr);
            end
        end
        mem_rdy_pct = 100;
        imem_req_ready = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (popped.size() <= k || popped[k] !== 32'(k * 4)) begin
                n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", k,
                                   (popped.size() > k) ? popped[k] : 32'hx, 32'(k * 4));
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        mem_rdy_pct = 100; cpu_rdy_pct = 100; lat_min = 4; lat_max = 4;
        do_reset();
        repeat (3) tick();
        mem_rdy_pct = 0;
        imem_req_ready = 1'b0;
        n_checks++;
        if (n_fires != 2) begin
            n_fail++; $display("FAIL redir_setup: got %0d requests want 2", n_fires);
        end
        popped.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        mem_rdy_pct = 100;
        imem_req_ready = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (popped.size() < 2 || popped[0] !== 32'h100 || popped[1] !== 32'h104) begin
            n_fail++; $display("FAIL redir_target: got %h,%h want 100,104",
                               (popped.size() > 0) ? popped[0] : 32'hx,
                               (popped.size() > 1) ? popped[1] : 32'hx);
        end
    endtask

    task automatic test_redirect_collision();
        logic [31:0] tgt;
        mem_rdy_pct = 100; cpu_rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (2) tick();
        tgt = $urandom;
        popped.delete();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        n_checks++;
        if (!(smp_fire && smp_rsp)) begin
            n_fail++; $display("FAIL collide_setup: got fire=%b rsp=%b want 1/1", smp_fire, smp_rsp);
        end
        repeat (12) tick();
        n_checks++;
        if (popped.size() == 0 || popped[0] !== (tgt & ~32'h3)) begin
            n_fail++; $display("FAIL collide_first: got %h want %h",
                               (popped.size() > 0) ? popped[0] : 32'hx, tgt & ~32'h3);
        end
    endtask

    task automatic test_wrap();
        mem_rdy_pct = 100; cpu_rdy_pct = 100; lat_min = 1; lat_max = 3;
        do_reset();
        repeat (3) tick();
        popped.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        repeat (25) tick();
        n_checks++;
        if (popped.size() < 3 || popped[0] !== 32'hFFFF_FFFC || popped[1] !== 32'h0
            || popped[2] !== 32'h4) begin
            n_fail++; $display("FAIL wrap: got %h,%h,%h want fffffffc,0,4",
                               (popped.size() > 0) ? popped[0] : 32'hx,
                               (popped.size() > 1) ? popped[1] : 32'hx,
                               (popped.size() > 2) ? popped[2] : 32'hx);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        mem_rdy_pct = 100; cpu_rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 100 && n_pops < 10; i++) tick();
        n_checks++;
        if (fetch_count !== 32'd10 || n_pops != 10) begin
            n_fail++; $display("FAIL perf_fetch: got %0d (pops %0d) want 10", fetch_count, n_pops);
        end
        n_checks++;
        if (bubble_count !== 32'(n_bubbles)) begin
            n_fail++; $display("FAIL perf_bubble: got %0d want %0d", bubble_count, n_bubbles);
        end
    endtask
`endif

    task automatic test_random();
        mem_rdy_pct = 70; cpu_rdy_pct = 60; lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            tick();
        end
        n_checks++;
        if (n_pops < 200) begin
            n_fail++; $display("FAIL rand_progress: got %0d pops want >=200", n_pops);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (fetch_count !== 32'(n_pops) || bubble_count !== 32'(n_bubbles)) begin
            n_fail++; $display("FAIL rand_perf: got %0d/%0d want %0d/%0d", fetch_count,
                               bubble_count, n_pops, n_bubbles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_req_stall();
        test_redirect_outstanding();
        test_redirect_collision();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage sitting directly upstream of the single-cycle R-type CPU; supplies the `instruction` word that the CPU decodes and executes.
- Owns the fetch PC and issues word-aligned read requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small prefetch queue.
- Presents instructions to the CPU with a valid/ready handshake.
- Supports a redirect (branch/jump target) that flushes all in-flight and queued work.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DEPTH, 4, prefetch queue entries (power of 2, >= 2); also the maximum outstanding-plus-queued instruction count
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_WIDTH  fetch address (word aligned)
imem_rsp_valid  in  1  response data valid (in order, never back-pressured)
imem_rsp_data  in  32  fetched instruction word
instr_valid  out  1  instruction available to CPU
instr_ready  in  1  CPU consumes instruction this cycle
instruction  out  32  instruction at queue head
instr_pc  out  ADDR_WIDTH  PC of `instruction`
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch target; bits [1:0] ignored (forced 0)

Behaviour:
- Reset values (reset low, async):
  - fetch_pc = rsp_pc = RESET_PC; imem_req_addr = RESET_PC.
  - imem_req_valid = 0, instr_valid = 0, instruction = 0, instr_pc = 0.
  - Queue empty, outstanding = 0, drop = 0, state = IDLE.
- FSM, IDLE -> FETCH:
  - Leaves IDLE one cycle after reset deasserts.
  - No request is issued in IDLE.
- FSM, FETCH:
  - imem_req_valid = 1 when outstanding + occupancy < DEPTH.
  - Request handshake (valid & ready): fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH); outstanding += 1.
  - imem_req_addr always equals fetch_pc.
- Response (imem_rsp_valid, drop == 0):
  - Pushes {rsp_pc, imem_rsp_data} into the queue.
  - rsp_pc += 4; outstanding -= 1.
- Queue:
  - instr_valid = !empty; instruction and instr_pc come from the head entry.
  - Handshake (instr_valid & instr_ready) pops the head.
  - Push and pop in the same cycle leave occupancy unchanged.
  - instr_ready while empty has no effect.
  - Overflow is impossible by the credit rule; an assertion checks this.
- Latency:
  - Request accepted in cycle N with response in cycle N+k -> instr_valid is high in cycle N+k+1.
  - Minimum is 2 cycles request-to-instruction with k = 1.
- Redirect (any state, highest priority):
  - Queue is cleared.
  - fetch_pc = rsp_pc = redirect_pc & ~3.
  - drop = outstanding, counting a request accepted in the same cycle and excluding a response arriving in the same cycle (that response is discarded).
  - State -> FLUSH; instr_valid goes low the next cycle.
  - An unaccepted pending request is withdrawn.
- FSM, FLUSH:
  - imem_req_valid = 0.
  - Each imem_rsp_valid decrements drop and outstanding and is not pushed.
  - When drop reaches 0 -> FETCH; requests resume that cycle at the target.
  - A redirect in FLUSH reloads the target only; drop is not changed.
- Counters are sized clog2(DEPTH)+1 bits.
- Reset asserted mid-operation returns all state to reset values immediately. Responses to pre-reset requests must not arrive after reset; this is a memory-side contract.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_count[31:0] and bubble_count[31:0].
  - fetch_count increments on every instr_valid & instr_ready.
  - bubble_count increments each cycle instr_ready & !instr_valid while not in reset.
  - Both counters wrap, and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 0, mem latency 1, instr_ready = 1 -> first instr_pc = 0x0 in cycle 3 after reset release, then 0x4, 0x8, 0xC on consecutive cycles with matching mem words.
- instr_ready = 0 for 20 cycles -> exactly DEPTH = 4 requests issued (addr 0x0..0xC), imem_req_valid low afterward, queue holds 4 entries; raising ready drains them in order.
- imem_req_ready held low for 5 cycles -> imem_req_addr stable at 0x0 throughout, no duplicate or skipped PC.
- Redirect to 0x103 with 2 responses outstanding -> next 2 responses dropped, next instr_pc = 0x100, then 0x104.
- Redirect in the same cycle as an accepted request and an arriving response -> both discarded; first delivered instr_pc = redirect target.
- fetch_pc = 0xFFFF_FFFC -> next request addr 0x0000_0000 (wrap). With FETCH_PERF_EN, after 10 consumed instructions fetch_count = 10.
